// File: rtl/seg7_pkg.sv
// Shared types and defaults for the seg7 scan multiplexer.
package seg7_pkg;

  localparam int N_DIGITS_DEF  = 4;
  localparam int DIV_DEF       = 50000;
  localparam int BLANK_CYC_DEF = 16;

  // Common-anode display: an anode is lit when its drive line is low.
  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter with BLANK/SHOW phase tracking.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int DIV       = DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_end_o,
  output logic in_show_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_state_e      state_q, state_d;

  // Counter and phase state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= BLANK;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Next-state logic for counter and phase.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_END) begin
          state_d = SHOW;
        end else begin
          state_d = BLANK;
        end
      end
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
        end else begin
          state_d = SHOW;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // in_show_o reports the phase entered at the next edge so the parent's
  // registered outputs line up with the phase they describe.
  assign slot_end_o = (cnt_q == CNT_LAST);
  assign in_show_o  = (state_d == SHOW);

endmodule

// File: rtl/seg7_scan_mux.sv
// Scan controller for a common-anode N-digit 7-segment display.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = N_DIGITS_DEF,
  parameter int DIV       = DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  output logic [3:0]            nibble,
  output logic [N_DIGITS-1:0]   an,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic slot_end_s;
  logic show_next_s;
  logic wrap_s;

  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0]      pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]           pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0][3:0]      shad_val_q, shad_val_d;
  logic [N_DIGITS-1:0]           shad_dp_q, shad_dp_d;
  logic [3:0]                    nibble_q, nibble_d;
  logic [N_DIGITS-1:0]           an_q, an_d;
  logic                          dp_q, dp_d;
  logic                          fd_q, fd_d;
  logic [N_DIGITS-1:0]           lit_s;

  seg7_slot_timer #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_end_o (slot_end_s),
    .in_show_o  (show_next_s)
  );

  assign wrap_s = slot_end_s && (idx_q == IDX_LAST);

  // Digit index, pending/shadow data and shadow copy at the frame boundary.
  // Shadow takes pending_q, so a load landing on the wrap edge waits a frame.
  always_comb begin
    idx_d      = idx_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    shad_val_d = shad_val_q;
    shad_dp_d  = shad_dp_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
    end else begin
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
    end
    if (wrap_s) begin
      idx_d      = '0;
      shad_val_d = pend_val_q;
      shad_dp_d  = pend_dp_q;
    end else if (slot_end_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Which digits may light during SHOW.
  always_comb begin
    lit_s = '1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
        zero_run = zero_run && (shad_val_d[k] == 4'h0);
        lit_s[k] = !zero_run;
      end
      lit_s[0] = 1'b1;
    end
`else
    lit_s = '1;
`endif
  end

  // Output next-state, computed from next-cycle index and phase.
  always_comb begin
    nibble_d = shad_val_d[idx_d];
    fd_d     = wrap_s;
    an_d     = '1;
    dp_d     = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (show_next_s && (idx_d == IDX_W'(k)) && lit_s[k]) begin
        an_d[k] = ANODE_ON;
      end else begin
        an_d[k] = ANODE_OFF;
      end
    end
    if (show_next_s) begin
      dp_d = shad_dp_d[idx_d];
    end else begin
      dp_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      shad_val_q <= '0;
      shad_dp_q  <= '0;
      nibble_q   <= 4'h0;
      an_q       <= '1;
      dp_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      shad_val_q <= shad_val_d;
      shad_dp_q  <= shad_dp_d;
      nibble_q   <= nibble_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end

  assign nibble     = nibble_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed, table-driven bench for seg7_scan_mux with N_DIGITS=4, DIV=8, BLANK_CYC=2.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp;
  logic        frame_done;

  seg7_scan_mux #(
    .N_DIGITS  (4),
    .DIV       (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .nibble     (nibble),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] val;
    logic [3:0]  dpi;
    logic        chk;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        dp;
    logic        fd;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   blank_cnt = 0;

  function automatic vec_t chkv(int c, logic [3:0] a, logic [3:0] nb, logic d, logic f);
    vec_t v;
    v = '{c, 1'b0, 16'h0000, 4'h0, 1'b1, a, nb, d, f};
    return v;
  endfunction

  function automatic vec_t ldv(int c, logic [15:0] v16, logic [3:0] dpi);
    vec_t v;
    v = '{c, 1'b1, v16, dpi, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outs(input logic [3:0] e_an, input logic [3:0] e_nib,
                            input logic e_dp, input logic e_fd);
    check("an", {28'h0, an}, {28'h0, e_an});
    check("nibble", {28'h0, nibble}, {28'h0, e_nib});
    check("dp", {31'h0, dp}, {31'h0, e_dp});
    check("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check("an_single_low", {31'h0, ($countones(~an) <= 1)}, 32'h1);
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    // Reset/idle, load ordering, mid-frame loads and a load on the wrap edge.
    tv.push_back(chkv(0,  4'b1111, 4'h0, 1'b0, 1'b0));
    tv.push_back(chkv(1,  4'b1111, 4'h0, 1'b0, 1'b0));
    tv.push_back(chkv(2,  4'b1110, 4'h0, 1'b0, 1'b0));
    tv.push_back(ldv (3,  16'h1A3F, 4'b0100));
    tv.push_back(chkv(7,  4'b1110, 4'h0, 1'b0, 1'b0));
    tv.push_back(chkv(8,  4'b1111, 4'h0, 1'b0, 1'b0));
    tv.push_back(chkv(10, 4'b1101, 4'h0, 1'b0, 1'b0));
    tv.push_back(chkv(18, 4'b1011, 4'h0, 1'b0, 1'b0));
    tv.push_back(chkv(26, 4'b0111, 4'h0, 1'b0, 1'b0));
    tv.push_back(chkv(31, 4'b0111, 4'h0, 1'b0, 1'b0));
    tv.push_back(chkv(32, 4'b1111, 4'hF, 1'b0, 1'b1));
    tv.push_back(chkv(33, 4'b1111, 4'hF, 1'b0, 1'b0));
    tv.push_back(chkv(34, 4'b1110, 4'hF, 1'b0, 1'b0));
    tv.push_back(chkv(40, 4'b1111, 4'h3, 1'b0, 1'b0));
    tv.push_back(chkv(42, 4'b1101, 4'h3, 1'b0, 1'b0));
    tv.push_back(chkv(48, 4'b1111, 4'hA, 1'b0, 1'b0));
    tv.push_back(ldv (50, 16'h1111, 4'b0000));
    tv.push_back(chkv(50, 4'b1011, 4'hA, 1'b1, 1'b0));
    tv.push_back(chkv(52, 4'b1011, 4'hA, 1'b1, 1'b0));
    tv.push_back(chkv(56, 4'b1111, 4'h1, 1'b0, 1'b0));
    tv.push_back(ldv (58, 16'h2222, 4'b0000));
    tv.push_back(chkv(58, 4'b0111, 4'h1, 1'b0, 1'b0));
    tv.push_back(chkv(60, 4'b0111, 4'h1, 1'b0, 1'b0));
    tv.push_back(chkv(64, 4'b1111, 4'h2, 1'b0, 1'b1));
    tv.push_back(chkv(65, 4'b1111, 4'h2, 1'b0, 1'b0));
    tv.push_back(chkv(66, 4'b1110, 4'h2, 1'b0, 1'b0));
    tv.push_back(chkv(74, 4'b1101, 4'h2, 1'b0, 1'b0));
    tv.push_back(chkv(82, 4'b1011, 4'h2, 1'b0, 1'b0));
    tv.push_back(chkv(90, 4'b0111, 4'h2, 1'b0, 1'b0));
    tv.push_back(ldv (95, 16'h3333, 4'b0000));
    tv.push_back(chkv(96, 4'b1111, 4'h2, 1'b0, 1'b1));
    tv.push_back(chkv(98, 4'b1110, 4'h2, 1'b0, 1'b0));
    tv.push_back(chkv(128, 4'b1111, 4'h3, 1'b0, 1'b1));
    tv.push_back(chkv(130, 4'b1110, 4'h3, 1'b0, 1'b0));

    // Reset held for three edges; anodes must be dark throughout.
    rst_n = 1'b0;
    load  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("an_in_reset", {28'h0, an}, 32'hF);
    end
    check_outs(4'b1111, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc   = 0;
    blank_cnt = 0;

    for (int n = 0; n <= 131; n++) begin
      load = 1'b0;
      foreach (tv[i]) begin
        if (tv[i].cyc == n) begin
          if (tv[i].ld) begin
            load  = 1'b1;
            value = tv[i].val;
            dp_in = tv[i].dpi;
          end
          if (tv[i].chk) check_outs(tv[i].an, tv[i].nib, tv[i].dp, tv[i].fd);
        end
      end
      if (an == 4'b1111) blank_cnt++;
      if ((n % 8) == 7) begin
        check("blank_cycles_per_slot", blank_cnt, 2);
        blank_cnt = 0;
      end
      tick();
    end
    load = 1'b0;

    // Asynchronous reset in the middle of digit 2's SHOW window.
    run_until(148);
    check_outs(4'b1011, 4'h3, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs(4'b1111, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    cyc   = 0;
    check_outs(4'b1111, 4'h0, 1'b0, 1'b0);
    run_until(2);
    check_outs(4'b1110, 4'h0, 1'b0, 1'b0);
    run_until(10);
    check_outs(4'b1101, 4'h0, 1'b0, 1'b0);

    // Leading-zero value: upper digits dark only when the feature is built in.
    value = 16'h0050;
    dp_in = 4'b0000;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    run_until(36);
    check_outs(4'b1110, 4'h0, 1'b0, 1'b0);
    run_until(44);
    check_outs(4'b1101, 4'h5, 1'b0, 1'b0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    run_until(52);
    check_outs(4'b1111, 4'h0, 1'b0, 1'b0);
    run_until(60);
    check_outs(4'b1111, 4'h0, 1'b0, 1'b0);
`else
    run_until(52);
    check_outs(4'b1011, 4'h0, 1'b0, 1'b0);
    run_until(60);
    check_outs(4'b0111, 4'h0, 1'b0, 1'b0);
`endif
    run_until(64);
    check_outs(4'b1111, 4'h0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
